fact_accel: RTL and testbench

FACT_ACCEL -- requirements
Module: fact_accel

---
 rtl/fact_pkg.sv | 26 ++
 rtl/fact_accel_if.sv | 10 +
 rtl/fact_dp.sv | 43 ++++
 rtl/fact_accel.sv | 160 ++++++++++++++++
 tb/tb_fact_accel.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/fact_pkg.sv
// rtl/fact_pkg.sv - shared state encodings, register offsets and limits for fact_accel
package fact_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } fact_state_e;

    localparam int ACC_W = 32;
    localparam int N_W   = 4;

    localparam logic [1:0] REG_N      = 2'd0;
    localparam logic [1:0] REG_GO     = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RESULT = 2'd3;

    localparam int STAT_DONE_BIT = 0;
    localparam int STAT_ERR_BIT  = 1;
    localparam int STAT_BUSY_BIT = 2;
    localparam int STAT_IRQ_BIT  = 3;

    localparam logic [N_W-1:0] FACT_MAX_N = 4'd12;

endpackage

// File: rtl/fact_accel_if.sv
// rtl/fact_accel_if.sv - CPU register bus (write strobe, word offset, write/read data)
interface fact_accel_if;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output we, output a, output wd, input rd);
    modport slave  (input we, input a, input wd, output rd);
endinterface

// File: rtl/fact_dp.sv
// rtl/fact_dp.sv - accumulator/counter datapath: acc <= acc*cnt while cnt > 1
module fact_dp
    import fact_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             calc,
    input  logic [N_W-1:0]   n,
    output logic [ACC_W-1:0] acc,
    output logic             cnt_gt1
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [N_W-1:0]   cnt_q, cnt_d;

    assign cnt_gt1 = (cnt_q > 4'd1);
    assign acc     = acc_q;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (load) begin
            acc_d = 32'd1;
            cnt_d = n;
        end else if (calc && cnt_gt1) begin
            // only the low 32 bits of the product are kept
            acc_d = acc_q * ACC_W'(cnt_q);
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fact_accel.sv
// rtl/fact_accel.sv - factorial accelerator: register file + FSM; FACT_IRQ_EN adds irq/irq_pend
module fact_accel
    import fact_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fact_accel_if.slave  bus
`ifdef FACT_IRQ_EN
    ,
    output logic         irq
`endif
);

    fact_state_e      state_q, state_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             go;
    logic             busy;
    logic             enter_done;
    logic             dp_load, dp_calc;
    logic [ACC_W-1:0] acc;
    logic             cnt_gt1;
    logic             irq_pend;
    logic [31:0]      status;
    logic             unused_wd;

    assign go        = bus.we && (bus.a == REG_GO) && bus.wd[0];
    assign busy      = (state_q == LOAD) || (state_q == CALC);
    assign unused_wd = ^bus.wd[31:4];

    fact_dp u_dp (
        .clk     (clk),
        .rst_n   (rst),
        .load    (dp_load),
        .calc    (dp_calc),
        .n       (n_q),
        .acc     (acc),
        .cnt_gt1 (cnt_gt1)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        result_d   = result_q;
        done_d     = done_q;
        err_d      = err_q;
        dp_load    = 1'b0;
        dp_calc    = 1'b0;
        enter_done = 1'b0;

        if (bus.we && (bus.a == REG_N)) begin
            n_d = bus.wd[N_W-1:0];
        end

        case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    if (n_q > FACT_MAX_N) begin
                        // out-of-range N finishes immediately, never touching the datapath
                        state_d    = DONE;
                        err_d      = 1'b1;
                        done_d     = 1'b1;
                        result_d   = '0;
                        enter_done = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                dp_load = 1'b1;
                state_d = CALC;
            end
            CALC: begin
                if (cnt_gt1) begin
                    dp_calc = 1'b1;
                end else begin
                    result_d   = acc;
                    done_d     = 1'b1;
                    state_d    = DONE;
                    enter_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

`ifdef FACT_IRQ_EN
    logic irq_q, irq_d;
    logic irq_pend_q, irq_pend_d;

    always_comb begin
        irq_d      = enter_done;
        irq_pend_d = irq_pend_q;
        if (bus.we && (bus.a == REG_STATUS) && bus.wd[STAT_IRQ_BIT]) begin
            irq_pend_d = 1'b0;
        end
        // a completion in the same cycle as the clear wins
        if (enter_done) begin
            irq_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q      <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            irq_q      <= irq_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    assign irq      = irq_q;
    assign irq_pend = irq_pend_q;
`else
    assign irq_pend = 1'b0;
`endif

    always_comb begin
        status                = '0;
        status[STAT_DONE_BIT] = done_q;
        status[STAT_ERR_BIT]  = err_q;
        status[STAT_BUSY_BIT] = busy;
        status[STAT_IRQ_BIT]  = irq_pend;
    end

    always_comb begin
        bus.rd = '0;
        case (bus.a)
            REG_N:      bus.rd = {28'd0, n_q};
            REG_GO:     bus.rd = '0;
            REG_STATUS: bus.rd = status;
            REG_RESULT: bus.rd = result_q;
            default:    bus.rd = '0;
        endcase
    end

endmodule

// File: tb/tb_fact_accel.sv
// tb/tb_fact_accel.sv - scoreboard bench for fact_accel with a factorial reference model
module tb_fact_accel;
    import fact_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fact_accel_if bus_if();

`ifdef FACT_IRQ_EN
    logic irq;
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    fact_accel dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
`ifdef FACT_IRQ_EN
        ,
        .irq (irq)
`endif
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    bit          rd_chk   = 1'b0;
    bit          pend_m   = 1'b0;
    int          irq_seen = 0;
    int          irq_exp  = 0;

    always @(negedge clk) begin
        logic [31:0] e;
        string       nm;
        if (rd_chk) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow: got 0x%08h with no expected value", bus_if.rd);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (bus_if.rd !== e) begin
                    failures++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", nm, bus_if.rd, e);
                end
            end
        end
`ifdef FACT_IRQ_EN
        if (irq === 1'b1) irq_seen++;
`endif
    end

    function automatic logic [31:0] fact_model(int n);
        logic [31:0] r;
        if (n > 12) return 32'd0;
        r = 32'd1;
        for (int i = 2; i <= n; i++) r = r * 32'(i);
        return r;
    endfunction

    function automatic logic [31:0] st(logic [2:0] base);
        return {28'd0, IRQ_EN & pend_m, base};
    endfunction

    task automatic step(int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [1:0] ad, logic [31:0] d);
        bus_if.we = 1'b1;
        bus_if.a  = ad;
        bus_if.wd = d;
        @(posedge clk);
        #1;
        bus_if.we = 1'b0;
        bus_if.wd = '0;
    endtask

    task automatic rd_exp(logic [1:0] ad, logic [31:0] e, string nm);
        bus_if.a = ad;
        exp_q.push_back(e);
        name_q.push_back(nm);
        rd_chk = 1'b1;
        @(posedge clk);
        #1;
        rd_chk = 1'b0;
    endtask

    task automatic completion();
        if (IRQ_EN) pend_m = 1'b1;
        irq_exp++;
    endtask

    logic [31:0] last_res;

    // GO is sampled at E0; a valid N finishes at edge max(N,1)+1, an out-of-range N at once
    task automatic run_fact(int n);
        int lat;
        wr(REG_N, 32'(n));
        rd_exp(REG_N, 32'(n), "n_readback");
        wr(REG_GO, 32'd1);
        if (n > 12) begin
            step(1);
            completion();
            rd_exp(REG_STATUS, st(3'b011), "err_status");
            rd_exp(REG_RESULT, 32'd0, "err_result");
            last_res = 32'd0;
        end else begin
            lat = ((n < 1) ? 1 : n) + 1;
            rd_exp(REG_STATUS, st(3'b100), "busy_first");
            if (lat > 2) step(lat - 2);
            rd_exp(REG_STATUS, st(3'b100), "busy_last");
            completion();
            rd_exp(REG_STATUS, st(3'b001), "done_status");
            last_res = fact_model(n);
            rd_exp(REG_RESULT, last_res, "result");
        end
    endtask

    initial begin
        rst       = 1'b0;
        bus_if.we = 1'b0;
        bus_if.a  = 2'd0;
        bus_if.wd = '0;
        step(1);
        for (int i = 0; i < 4; i++) rd_exp(2'(i), 32'd0, "reset_reg");
        rst = 1'b1;
        step(1);

        run_fact(5);
        run_fact(0);
        run_fact(12);
        run_fact(13);
        run_fact(3);
        run_fact(1);

        wr(REG_STATUS, 32'hFFFF_FFF7);
        wr(REG_RESULT, 32'hDEAD_BEEF);
        wr(REG_GO, 32'd0);
        rd_exp(REG_STATUS, st(3'b001), "ro_write_status");
        rd_exp(REG_RESULT, last_res, "ro_write_result");
        rd_exp(REG_GO, 32'd0, "go_reads_zero");

        // GO and an N write while busy must not disturb the running N=4 job
        wr(REG_N, 32'd4);
        wr(REG_GO, 32'd1);
        step(2);
        wr(REG_N, 32'd9);
        wr(REG_GO, 32'd1);
        rd_exp(REG_STATUS, st(3'b100), "busy_ignore_go");
        completion();
        rd_exp(REG_STATUS, st(3'b001), "ignore_go_status");
        rd_exp(REG_RESULT, fact_model(4), "ignore_go_result");
        rd_exp(REG_N, 32'd9, "n_written_busy");

        wr(REG_N, 32'd7);
        wr(REG_GO, 32'd1);
        step(2);
        rst = 1'b0;
        pend_m = 1'b0;
        #1;
        rd_exp(REG_STATUS, 32'd0, "rst_status");
        rd_exp(REG_RESULT, 32'd0, "rst_result");
        rd_exp(REG_N, 32'd0, "rst_n_reg");
        rst = 1'b1;
        step(1);
        run_fact(7);

`ifdef FACT_IRQ_EN
        begin
            int irq0;
            irq0 = irq_seen;
            run_fact(2);
            step(1);
            checks++;
            if (irq_seen != irq0 + 1) begin
                failures++;
                $display("FAIL irq_single_pulse: got %0d pulses expected 1", irq_seen - irq0);
            end
            wr(REG_STATUS, 32'h8);
            pend_m = 1'b0;
            rd_exp(REG_STATUS, st(3'b001), "irq_pend_clear");
        end
`endif

        for (int i = 0; i < 20; i++) begin
            run_fact(int'($urandom_range(0, 15)));
        end

        step(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
`ifdef FACT_IRQ_EN
        checks++;
        if (irq_seen != irq_exp) begin
            failures++;
            $display("FAIL irq_count: got %0d expected %0d", irq_seen, irq_exp);
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
